// File: rtl/vga_block_renderer.sv
// Block-mode VGA scan-out: 640x480@60 timing from a 50 MHz clock with a pixel enable, reading one
// colour word per 20x20 block from memory port B. The scan geometry is parameterised.
module vga_block_renderer #(
  parameter logic [9:0] BASE_ADDR = 10'd256,
  parameter int BLOCK_PX = 20,
  parameter int COLS     = 32,
  parameter int ROWS     = 24,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_data,
  output logic [9:0]  mem_addr,
  output logic        mem_we,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        active,
  output logic        frame_start
);

  localparam int H_ACT = COLS * BLOCK_PX;
  localparam int V_ACT = ROWS * BLOCK_PX;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int SW = $clog2(BLOCK_PX + 1);
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0] HS_START = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0] V_ACT_M1 = VW'(V_ACT - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);
  localparam logic [SW-1:0] SUB_LAST = SW'(BLOCK_PX - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic          pix_en;
  logic [HW-1:0] h_count, h_nx;
  logic [VW-1:0] v_count, v_nx;
  logic [SW-1:0] sub_x, sub_x_nx, sub_y, sub_y_nx;
  logic [CW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx, next_row;
  logic [11:0]   cur_color, color_nx;
  logic [9:0]    addr_nx;
  logic          h_wrap, v_wrap, new_block, act_nx;
  logic          unused_hi;

  assign mem_we    = 1'b0;
  assign unused_hi = ^mem_data[15:12];

  always_comb begin
    h_wrap   = (h_count == H_LAST);
    h_nx     = h_wrap ? '0 : h_count + 1'b1;
    v_wrap   = h_wrap && (v_count == V_LAST);
    v_nx     = v_wrap ? '0 : (h_wrap ? v_count + 1'b1 : v_count);

    // Block counters freeze outside the active window so col never runs past COLS-1.
    sub_x_nx = sub_x;
    col_nx   = col;
    if (h_wrap) begin
      sub_x_nx = '0;
      col_nx   = '0;
    end else if (h_nx < H_ACT_C) begin
      sub_x_nx = (sub_x == SUB_LAST) ? '0 : sub_x + 1'b1;
      col_nx   = (sub_x == SUB_LAST) ? col + 1'b1 : col;
    end

    sub_y_nx = sub_y;
    row_nx   = row;
    if (v_wrap) begin
      sub_y_nx = '0;
      row_nx   = '0;
    end else if (h_wrap && (v_nx < V_ACT_C)) begin
      sub_y_nx = (sub_y == SUB_LAST) ? '0 : sub_y + 1'b1;
      row_nx   = (sub_y == SUB_LAST) ? row + 1'b1 : row;
    end

    new_block = (h_nx < H_ACT_C) && (h_wrap || (sub_x == SUB_LAST));
    color_nx  = new_block ? mem_data[11:0] : cur_color;
    next_row  = (v_count < V_ACT_M1) ? ((sub_y == SUB_LAST) ? row + 1'b1 : row) : '0;

    // Address runs one block ahead of the displayed colour; reloaded to the next line's base in h blanking.
    addr_nx = mem_addr;
    if (h_nx == H_ACT_C)
      addr_nx = BASE_ADDR + 10'(next_row) * 10'(COLS);
    else if (new_block && (col_nx != COL_LAST))
      addr_nx = mem_addr + 10'd1;

    act_nx = (h_nx < H_ACT_C) && (v_nx < V_ACT_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_en      <= 1'b0;
      h_count     <= '0;
      v_count     <= '0;
      sub_x       <= '0;
      col         <= '0;
      sub_y       <= '0;
      row         <= '0;
      mem_addr    <= BASE_ADDR;
      cur_color   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_en      <= ~pix_en;
      frame_start <= 1'b0;
      if (pix_en) begin
        h_count     <= h_nx;
        v_count     <= v_nx;
        sub_x       <= sub_x_nx;
        col         <= col_nx;
        sub_y       <= sub_y_nx;
        row         <= row_nx;
        mem_addr    <= addr_nx;
        cur_color   <= color_nx;
        hsync       <= !((h_nx >= HS_START) && (h_nx < HS_END));
        vsync       <= !((v_nx >= VS_START) && (v_nx < VS_END));
        active      <= act_nx;
        red         <= act_nx ? color_nx[11:8] : 4'd0;
        green       <= act_nx ? color_nx[7:4]  : 4'd0;
        blue        <= act_nx ? color_nx[3:0]  : 4'd0;
        frame_start <= (h_nx == '0) && (v_nx == '0);
      end
    end
  end

endmodule

// File: tb/tb_vga_block_renderer.sv
// Scaled-geometry bench: the expected scan position is derived from the clock count since reset,
// and pixel colours come straight from the bench memory image.
module tb_vga_block_renderer;
  localparam int BP = 4, COLS = 8, ROWS = 6;
  localparam int HFP = 4, HS = 8, HBP = 4, VFP = 2, VS = 2, VBP = 2;
  localparam int BASE = 256;
  localparam int HA = COLS * BP, VA = ROWS * BP;
  localparam int HT = HA + HFP + HS + HBP, VT = VA + VFP + VS + VBP;
  localparam int TOT = HT * VT;
  localparam int NW = COLS * ROWS;

  logic        clk, reset;
  logic [15:0] mem_data;
  logic [9:0]  mem_addr;
  logic        mem_we, hsync, vsync, active, frame_start;
  logic [3:0]  red, green, blue;

  vga_block_renderer #(
    .BASE_ADDR(10'(BASE)), .BLOCK_PX(BP), .COLS(COLS), .ROWS(ROWS),
    .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .mem_data(mem_data), .mem_addr(mem_addr), .mem_we(mem_we),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .active(active), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [15:0] mem [0:1023];
  always @(posedge clk) mem_data <= mem[mem_addr];

  // Clock edges since the last reset edge; every second one is a pixel advance.
  int n;
  always @(posedge clk) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  int checks = 0, fails = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (n=%0d)", name, act, exp, n);
    end
  endtask

  function automatic bit pinned(input int a);
    return (a == 0) || (a == 1) || (a == COLS) || (a == NW - 1);
  endfunction

  int cyc = 0, last_fs = 0, nfs = 0, hlow = 0, vlow = 0;
  bit have_last = 1'b0;

  always @(negedge clk) begin
    int k, p, h, v, e_rgb, rgb;
    bit adv;
    cyc++;
    if (started) begin
      k   = n / 2;
      adv = (n % 2 == 0);
      rgb = {red, green, blue};
      if (n == 0) begin
        have_last = 1'b0;
        hlow = 0;
        vlow = 0;
      end
      if (k == 0) begin
        chk("reset_hsync", hsync, 1);
        chk("reset_vsync", vsync, 1);
        chk("reset_active", active, 0);
        chk("reset_rgb", rgb, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_mem_addr", mem_addr, BASE);
        v = 0;
      end else begin
        p = k % TOT;
        h = p % HT;
        v = p / HT;
        chk("hsync", hsync, !(h >= HA + HFP && h < HA + HFP + HS));
        chk("vsync", vsync, !(v >= VA + VFP && v < VA + VFP + VS));
        chk("active", active, (h < HA) && (v < VA));
        chk("frame_start", frame_start, adv && (p == 0));
        if (!(h < HA && v < VA)) chk("blank_rgb", rgb, 0);
        else if (k >= TOT) begin
          e_rgb = int'(mem[BASE + (v / BP) * COLS + h / BP][11:0]);
          chk("pixel_rgb", rgb, e_rgb);
        end
        if (adv && k >= TOT) begin
          if (h == 0 && v == 0)            chk("lit_px0_line0", rgb, 'hF00);
          if (h == BP && v == 0)           chk("lit_blk1_line0", rgb, 'h0F0);
          if (h == 0 && v == BP)           chk("lit_row1_px0", rgb, 'h00F);
          if (h == 0 && v == BP - 1)       chk("lit_row0_last_line", rgb, 'hF00);
          if (h == HA - 1 && v == VA - 1)  chk("lit_last_px", {active, rgb[11:0]}, 'h1FFF);
          if (h == HA && v == VA - 1)      chk("lit_after_last", {active, rgb[11:0]}, 'h0000);
        end
      end
      chk("mem_we", mem_we, 0);
      chk("mem_addr_range", (mem_addr >= BASE) && (mem_addr < BASE + NW), 1);

      if (frame_start) begin
        if (have_last) chk("frame_period_clks", cyc - last_fs, 2 * TOT);
        else           chk("reset_to_frame_clks", n, 2 * TOT);
        last_fs   = cyc;
        have_last = 1'b1;
        nfs++;
      end
      if (!hsync) hlow++;
      else begin
        if (hlow > 0) chk("hsync_low_clks", hlow, 2 * HS);
        hlow = 0;
      end
      if (!vsync) vlow++;
      else begin
        if (vlow > 0) chk("vsync_low_clks", vlow, 2 * VS * HT);
        vlow = 0;
      end

      // CPU-style writes only in vertical blanking, where no displayed fetch can tear.
      if (k > 0 && v >= VA + 1 && v <= VT - 3 && $urandom_range(0, 3) == 0) begin
        p = $urandom_range(0, NW - 1);
        if (!pinned(p)) mem[BASE + p] = 16'($urandom);
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[BASE]          = 16'h0F00;
    mem[BASE + 1]      = 16'h00F0;
    mem[BASE + COLS]   = 16'h000F;
    mem[BASE + NW - 1] = 16'hFFFF;
    @(posedge clk); #1 started = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * (3 * TOT + 10 * HT + 20)) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2 * 3 * TOT + 100) @(posedge clk);
    #1;
    chk("frame_start_count", nfs, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
